// File: rtl/packet_gen.sv
// Traffic source for one mesh node: builds 64-bit packets and pushes them into
// the router's local injection channel, with LFSR or fixed destinations.
module packet_gen #(
  parameter int          MESH_X     = 8,
  parameter int          MESH_Y     = 8,
  parameter int          GAP        = 4,
  parameter int          MAX_PKTS   = 16,
  parameter logic [31:0] SEED       = 32'hACE1_1234,
  parameter int          FIXED_DEST = 0,
  parameter int          FIX_X      = 0,
  parameter int          FIX_Y      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  X_cur,
  input  logic [2:0]  Y_cur,
  input  logic        j_e,
  input  logic        push_j_ack,
  output logic [63:0] inject,
  output logic        push_j,
  output logic [15:0] pkt_cnt,
  output logic        done
);

  localparam logic [3:0]  MX       = 4'(MESH_X);
  localparam logic [3:0]  MY       = 4'(MESH_Y);
  localparam logic [2:0]  FX       = 3'(FIX_X);
  localparam logic [2:0]  FY       = 3'(FIX_Y);
  localparam logic [15:0] GAP_INIT = 16'(GAP);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_PKTS);
  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  typedef enum logic [1:0] {GAP_WAIT, ROOM_WAIT, PUSH, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] gap_cnt, gap_n;
  logic [31:0] lfsr, lfsr_n, lfsr_adv;
  logic [31:0] seed_mix, seed_val;
  logic [63:0] inject_n;
  logic        push_n;
  logic [15:0] cnt_n, cnt_inc;
  logic        done_n;
  logic [2:0]  rx, ry, dst_x, dst_y;

  // Per-node seed so neighbouring generators do not march in lockstep
  assign seed_mix = SEED ^ {26'b0, X_cur, Y_cur};
  assign seed_val = (seed_mix == 32'd0) ? 32'd1 : seed_mix;

  assign lfsr_adv = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & TAPS);
  assign cnt_inc  = pkt_cnt + 16'd1;

  always_comb begin
    rx    = ({1'b0, lfsr[2:0]} >= MX) ? lfsr[2:0] - MX[2:0] : lfsr[2:0];
    ry    = ({1'b0, lfsr[5:3]} >= MY) ? lfsr[5:3] - MY[2:0] : lfsr[5:3];
    dst_x = rx;
    dst_y = ry;
    if (FIXED_DEST != 0) begin
      dst_x = FX;
      dst_y = FY;
    end else if (rx == X_cur && ry == Y_cur) begin
      // Step one column over so a node never targets itself
      dst_x = (({1'b0, rx} + 4'd1) == MX) ? 3'd0 : rx + 3'd1;
    end
  end

  always_comb begin
    state_n  = state;
    gap_n    = gap_cnt;
    lfsr_n   = lfsr;
    inject_n = inject;
    push_n   = push_j;
    cnt_n    = pkt_cnt;
    done_n   = done;
    case (state)
      GAP_WAIT: begin
        if (en) begin
          if (gap_cnt == 16'd0) begin
            inject_n = {dst_x, dst_y, X_cur, Y_cur, pkt_cnt, 4'h0, lfsr};
            state_n  = ROOM_WAIT;
          end else begin
            gap_n = gap_cnt - 16'd1;
          end
        end
      end
      ROOM_WAIT: begin
        if (!en) begin
          state_n = GAP_WAIT;
        end else if (j_e) begin
          push_n  = 1'b1;
          state_n = PUSH;
        end
      end
      PUSH: begin
        if (push_j_ack) begin
          push_n = 1'b0;
          cnt_n  = cnt_inc;
          lfsr_n = lfsr_adv;
          gap_n  = GAP_INIT;
          if (MAX_PKTS != 0 && cnt_inc == MAX_CNT) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = GAP_WAIT;
          end
        end
      end
      DONE: begin
        push_n = 1'b0;
        done_n = 1'b1;
      end
      default: state_n = GAP_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= GAP_WAIT;
      gap_cnt <= GAP_INIT;
      lfsr    <= seed_val;
      inject  <= 64'd0;
      push_j  <= 1'b0;
      pkt_cnt <= 16'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      lfsr    <= lfsr_n;
      inject  <= inject_n;
      push_j  <= push_n;
      pkt_cnt <= cnt_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_packet_gen.sv
// Self-checking bench for packet_gen: a cycle table plus handshake corner cases
// on a fixed-destination node, a packet-budget node and a randomized LFSR node.
module tb_packet_gen;

  localparam logic [31:0] SEED   = 32'hACE1_1234;
  localparam int          N_VEC  = 17;
  localparam int          N_RAND = 1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        f_en = 1'b0, f_je = 1'b0, f_ack = 1'b0;
  logic [2:0]  f_x = 3'd1, f_y = 3'd3;
  logic [63:0] f_inject;
  logic        f_push, f_done;
  logic [15:0] f_cnt;

  logic        m_en = 1'b0, m_je = 1'b0, m_ack = 1'b0;
  logic [2:0]  m_x = 3'd2, m_y = 3'd2;
  logic [63:0] m_inject;
  logic        m_push, m_done;
  logic [15:0] m_cnt;

  logic        r_en = 1'b0, r_je = 1'b0, r_ack = 1'b0;
  logic [2:0]  r_x = 3'd0, r_y = 3'd0;
  logic [63:0] r_inject;
  logic        r_push, r_done;
  logic [15:0] r_cnt;

  packet_gen #(.GAP(0), .MAX_PKTS(0), .FIXED_DEST(1), .FIX_X(5), .FIX_Y(2)) dut_f (
    .clk(clk), .reset(reset), .en(f_en), .X_cur(f_x), .Y_cur(f_y), .j_e(f_je),
    .push_j_ack(f_ack), .inject(f_inject), .push_j(f_push), .pkt_cnt(f_cnt), .done(f_done));

  packet_gen #(.GAP(2), .MAX_PKTS(3)) dut_m (
    .clk(clk), .reset(reset), .en(m_en), .X_cur(m_x), .Y_cur(m_y), .j_e(m_je),
    .push_j_ack(m_ack), .inject(m_inject), .push_j(m_push), .pkt_cnt(m_cnt), .done(m_done));

  packet_gen #(.MESH_X(5), .MESH_Y(6), .GAP(1), .MAX_PKTS(0)) dut_r (
    .clk(clk), .reset(reset), .en(r_en), .X_cur(r_x), .Y_cur(r_y), .j_e(r_je),
    .push_j_ack(r_ack), .inject(r_inject), .push_j(r_push), .pkt_cnt(r_cnt), .done(r_done));

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        en;
    logic        j_e;
    logic        ack;
    logic        exp_push;
    logic [15:0] exp_cnt;
    logic [63:0] exp_inject;
  } vec_t;

  vec_t vecs [N_VEC];

  // Multiply the LFSR state by x modulo the polynomial, one tap exponent at a time
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    int exps [4];
    logic [31:0] r;
    exps = '{32, 22, 2, 1};
    r = s >> 1;
    if (s[0]) foreach (exps[i]) r[exps[i]-1] = ~r[exps[i]-1];
    return r;
  endfunction

  function automatic logic [31:0] seed_for(input logic [2:0] x, input logic [2:0] y);
    logic [31:0] s;
    s = SEED ^ {26'b0, x, y};
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

  function automatic logic [31:0] lfsr_after(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  function automatic logic [63:0] expected_packet(input logic [31:0] l, input int seq,
                                                  input int xc, input int yc,
                                                  input int mx, input int my);
    int dx, dy;
    dx = int'(l[2:0]) % mx;
    dy = int'(l[5:3]) % my;
    if (dx == xc && dy == yc) dx = (dx + 1) % mx;
    return {3'(dx), 3'(dy), 3'(xc), 3'(yc), 16'(seq), 4'h0, l};
  endfunction

  // Fixed destination (5,2) from node (1,3): header 101_010_001_011
  function automatic logic [63:0] f_pkt(input int seq);
    return {12'hA8B, 16'(seq), 4'h0, lfsr_after(seed_for(3'd1, 3'd3), seq)};
  endfunction

  function automatic vec_t mk(input logic en, input logic je, input logic ack,
                              input logic push, input int cnt, input int seq);
    vec_t v;
    v.en = en; v.j_e = je; v.ack = ack;
    v.exp_push = push; v.exp_cnt = 16'(cnt); v.exp_inject = f_pkt(seq);
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    f_en  = v.en;
    f_je  = v.j_e;
    f_ack = v.ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    bit          prev_push, prev_ack;
    int          acks, rises, low_run, min_gap, mcnt, cyc;
    logic [31:0] mod_lfsr, last_payload;
    logic [63:0] exp_pkt;
    bit          have_last;

    vecs[0]  = mk(1, 1, 1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 1, 1);
    vecs[5]  = mk(1, 0, 0, 0, 1, 1);
    vecs[6]  = mk(1, 0, 0, 0, 1, 1);
    vecs[7]  = mk(1, 1, 0, 1, 1, 1);
    vecs[8]  = mk(1, 0, 1, 0, 2, 1);
    vecs[9]  = mk(0, 1, 0, 0, 2, 1);
    vecs[10] = mk(1, 0, 0, 0, 2, 2);
    vecs[11] = mk(0, 1, 0, 0, 2, 2);
    vecs[12] = mk(1, 0, 0, 0, 2, 2);
    vecs[13] = mk(1, 1, 0, 1, 2, 2);
    vecs[14] = mk(0, 0, 0, 1, 2, 2);
    vecs[15] = mk(0, 0, 1, 0, 3, 2);
    vecs[16] = mk(0, 1, 0, 0, 3, 2);

    repeat (3) step();
    check_output("reset_inject", f_inject, 64'd0);
    check_output("reset_push", 64'(f_push), 64'd0);
    check_output("reset_cnt", 64'(f_cnt), 64'd0);
    check_output("reset_done", 64'(f_done), 64'd0);

    for (int i = 0; i < N_VEC; i++) begin
      apply_stimulus(vecs[i]);
      if (i == 0) reset = 1'b0;
      step();
      check_output($sformatf("vec%0d_push", i), 64'(f_push), 64'(vecs[i].exp_push));
      check_output($sformatf("vec%0d_cnt", i), 64'(f_cnt), 64'(vecs[i].exp_cnt));
      check_output($sformatf("vec%0d_inject", i), f_inject, vecs[i].exp_inject);
      check_output($sformatf("vec%0d_done", i), 64'(f_done), 64'd0);
    end

    // Ack withheld for 10 cycles: word must stay put
    f_en = 1'b1; f_je = 1'b1; f_ack = 1'b0;
    step();
    step();
    check_output("hold_push_rise", 64'(f_push), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_output("hold_push", 64'(f_push), 64'd1);
      check_output("hold_inject", f_inject, f_pkt(3));
      check_output("hold_cnt", 64'(f_cnt), 64'd3);
    end
    f_ack = 1'b1;
    step();
    check_output("hold_ack_cnt", 64'(f_cnt), 64'd4);
    check_output("hold_ack_push", 64'(f_push), 64'd0);
    f_ack = 1'b0;

    // No room for 20 cycles
    f_je = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_output("stall_push", 64'(f_push), 64'd0);
    end
    f_je = 1'b1;
    step();
    check_output("stall_release_push", 64'(f_push), 64'd1);
    check_output("stall_release_inject", f_inject, f_pkt(4));

    // Reset while a push is pending
    reset = 1'b1;
    step();
    check_output("midreset_push", 64'(f_push), 64'd0);
    check_output("midreset_cnt", 64'(f_cnt), 64'd0);
    reset = 1'b0;
    step();
    check_output("latency_c1_push", 64'(f_push), 64'd0);
    step();
    check_output("latency_c2_push", 64'(f_push), 64'd1);
    check_output("midreset_seq0_inject", f_inject, f_pkt(0));
    f_ack = 1'b1;
    step();
    check_output("midreset_ack_cnt", 64'(f_cnt), 64'd1);
    f_ack = 1'b0; f_en = 1'b0;

    // Packet budget of 3 with GAP=2
    pulse_reset();
    m_en = 1'b1; m_je = 1'b1; m_ack = 1'b1;
    prev_push = 1'b0; acks = 0; rises = 0; low_run = 0; min_gap = 1000;
    mod_lfsr = seed_for(3'd2, 3'd2);
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev_push) begin
        acks++;
        mod_lfsr = lfsr_step(mod_lfsr);
      end
      if (m_push && !prev_push) begin
        check_output("m_inject", m_inject, expected_packet(mod_lfsr, acks, 2, 2, 8, 8));
        check_output("m_seq", 64'(m_inject[51:36]), 64'(rises));
        if (rises > 0 && low_run < min_gap) min_gap = low_run;
        rises++;
        low_run = 0;
      end
      if (!m_push) low_run++;
      check_output("m_done", 64'(m_done), 64'(acks >= 3));
      prev_push = m_push;
    end
    check_output("m_push_count", 64'(rises), 64'd3);
    check_output("m_final_cnt", 64'(m_cnt), 64'd3);
    check_output("m_min_gap_ge2", 64'(min_gap >= 2), 64'd1);
    m_en = 1'b0; m_je = 1'b0; m_ack = 1'b0;

    // Randomized LFSR destinations from node (0,0) on a 5x6 mesh
    pulse_reset();
    prev_push = 1'b0; prev_ack = 1'b0; mcnt = 0; cyc = 0; have_last = 1'b0;
    last_payload = 32'd0;
    mod_lfsr = seed_for(3'd0, 3'd0);
    r_en = 1'b1; r_je = 1'b1; r_ack = 1'b0;
    while (mcnt < N_RAND && cyc < 40000) begin
      step();
      cyc++;
      if (prev_push && prev_ack) begin
        mcnt++;
        mod_lfsr = lfsr_step(mod_lfsr);
        check_output("r_push_drop", 64'(r_push), 64'd0);
      end
      check_output("r_pkt_cnt", 64'(r_cnt), 64'(16'(mcnt)));
      if (r_push) begin
        exp_pkt = expected_packet(mod_lfsr, mcnt, 0, 0, 5, 6);
        check_output("r_inject", r_inject, exp_pkt);
        if (!prev_push) begin
          check_output("r_dst_not_self", 64'(r_inject[63:58] != 6'd0), 64'd1);
          check_output("r_dst_in_mesh",
                       64'(r_inject[63:61] < 3'd5 && r_inject[60:58] < 3'd6), 64'd1);
          if (have_last)
            check_output("r_payload_changes", 64'(r_inject[31:0] != last_payload), 64'd1);
          last_payload = r_inject[31:0];
          have_last = 1'b1;
        end
      end
      prev_push = r_push;
      r_en  = ($urandom_range(9) != 0);
      r_je  = ($urandom_range(3) != 0);
      r_ack = ($urandom_range(2) == 0);
      prev_ack = r_ack;
    end
    check_output("r_all_packets_seen", 64'(mcnt), 64'(N_RAND));
    r_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
